// File: rtl/pipeline_pkg.sv
// Shared types and constants for the EX-stage forwarding / hazard control.
package pipeline_pkg;

    localparam int unsigned REG_IDX_BITS = 5;

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    localparam logic [REG_IDX_BITS-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                    valido;
        logic [REG_IDX_BITS-1:0] rd;
        logic                    escreve;
        logic                    le_mem;
    } slot_t;

endpackage

// File: rtl/unidade_adiantamento_hazard_if.sv
// Bundle between the ID stage and the forwarding/hazard unit.
interface unidade_adiantamento_hazard_if #(
    parameter int unsigned REG_BITS  = 5,
    parameter int unsigned CNT_WIDTH = 16
) ();

    logic                 id_valido;
    logic [REG_BITS-1:0]  id_rs;
    logic [REG_BITS-1:0]  id_rt;
    logic                 id_usa_rs;
    logic                 id_usa_rt;
    logic [REG_BITS-1:0]  id_rd;
    logic                 id_escreve_reg;
    logic                 id_le_mem;
    logic                 desvio_tomado;
    logic [1:0]           sel_a;
    logic [1:0]           sel_b;
    logic                 stall;
    logic                 bolha;
    logic [CNT_WIDTH-1:0] cnt_stall;
    logic [CNT_WIDTH-1:0] cnt_flush;

    modport master (
        output id_valido, id_rs, id_rt, id_usa_rs, id_usa_rt, id_rd, id_escreve_reg,
               id_le_mem, desvio_tomado,
        input  sel_a, sel_b, stall, bolha, cnt_stall, cnt_flush
    );

    modport slave (
        input  id_valido, id_rs, id_rt, id_usa_rs, id_usa_rt, id_rd, id_escreve_reg,
               id_le_mem, desvio_tomado,
        output sel_a, sel_b, stall, bolha, cnt_stall, cnt_flush
    );

endinterface

// File: rtl/comparador_adiantamento.sv
// Priority compare of one source register against the EX and MEM shadow slots.
module comparador_adiantamento
    import pipeline_pkg::*;
(
    input  logic [REG_IDX_BITS-1:0] src,
    input  logic                    usa,
    input  slot_t                   ex,
    input  logic                    mem_valido,
    input  logic [REG_IDX_BITS-1:0] mem_rd,
    input  logic                    mem_escreve,
    output logic [1:0]              sel,
    output logic                    uso_carga
);

    always_comb begin
        sel       = SEL_REG;
        uso_carga = 1'b0;
        if (usa && src != REG_ZERO) begin
            // A load in EX has no data yet: it cannot forward, it can only stall.
            if (ex.valido && ex.escreve && ex.rd == src && !ex.le_mem) begin
                sel = SEL_MEM;
            end else if (mem_valido && mem_escreve && mem_rd == src) begin
                sel = SEL_WB;
            end
            uso_carga = ex.valido && ex.le_mem && ex.rd == src;
        end
    end

endmodule

// File: rtl/unidade_adiantamento_hazard.sv
// EX-operand forwarding select generation, load-use stall and branch-flush bubble control.
module unidade_adiantamento_hazard
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_BITS  = REG_IDX_BITS,
    parameter int unsigned CNT_WIDTH = 16
) (
    input logic                          clk,
    input logic                          reset,
    unidade_adiantamento_hazard_if.slave bus
);

    logic [REG_BITS-1:0]  rs, rt, rd;
    slot_t                id_slot, ex_q;
    // The WB stage is not tracked: the register file writes before it reads.
    logic                 mem_valido_q, mem_escreve_q;
    logic [REG_BITS-1:0]  mem_rd_q;
    logic [1:0]           sel_a_c, sel_b_c, sel_a_q, sel_b_q;
    logic                 carga_a, carga_b, stall, bolha;
    logic [CNT_WIDTH-1:0] cnt_stall_q, cnt_flush_q;

    assign rs = bus.id_rs;
    assign rt = bus.id_rt;
    assign rd = bus.id_rd;

    assign id_slot = '{valido: bus.id_valido, rd: rd, escreve: bus.id_escreve_reg,
                       le_mem: bus.id_le_mem};

    comparador_adiantamento u_cmp_a (
        .src         (rs),
        .usa         (bus.id_usa_rs),
        .ex          (ex_q),
        .mem_valido  (mem_valido_q),
        .mem_rd      (mem_rd_q),
        .mem_escreve (mem_escreve_q),
        .sel         (sel_a_c),
        .uso_carga   (carga_a)
    );

    comparador_adiantamento u_cmp_b (
        .src         (rt),
        .usa         (bus.id_usa_rt),
        .ex          (ex_q),
        .mem_valido  (mem_valido_q),
        .mem_rd      (mem_rd_q),
        .mem_escreve (mem_escreve_q),
        .sel         (sel_b_c),
        .uso_carga   (carga_b)
    );

    assign stall = bus.id_valido && (carga_a || carga_b);
    assign bolha = stall || bus.desvio_tomado;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q          <= '0;
            mem_valido_q  <= 1'b0;
            mem_rd_q      <= '0;
            mem_escreve_q <= 1'b0;
            sel_a_q       <= SEL_REG;
            sel_b_q       <= SEL_REG;
            cnt_stall_q   <= '0;
            cnt_flush_q   <= '0;
        end else begin
            mem_valido_q  <= ex_q.valido;
            mem_rd_q      <= ex_q.rd;
            mem_escreve_q <= ex_q.escreve;
            if (bolha) begin
                ex_q    <= '0;
                sel_a_q <= SEL_REG;
                sel_b_q <= SEL_REG;
            end else begin
                ex_q    <= id_slot;
                sel_a_q <= bus.id_valido ? sel_a_c : SEL_REG;
                sel_b_q <= bus.id_valido ? sel_b_c : SEL_REG;
            end
            // A flush supersedes a coincident stall, so only the flush is counted.
            if (bus.desvio_tomado) begin
                if (cnt_flush_q != '1) cnt_flush_q <= cnt_flush_q + 1'b1;
            end else if (stall) begin
                if (cnt_stall_q != '1) cnt_stall_q <= cnt_stall_q + 1'b1;
            end
        end
    end

    assign bus.sel_a     = sel_a_q;
    assign bus.sel_b     = sel_b_q;
    assign bus.stall     = stall;
    assign bus.bolha     = bolha;
    assign bus.cnt_stall = cnt_stall_q;
    assign bus.cnt_flush = cnt_flush_q;

endmodule
